grad_mag: RTL and testbench
===========================

# grad_mag

Gradient-magnitude/direction stage directly downstream of the image-gradient block. It scans the packed gradient memory ({Gx,Gy}, 10-bit signed each) once per start. For every entry it computes a saturated L1 magnitude and a 2-bit quantized edge direction, and writes the packed result to a magnitude memory, one entry per clock after a fixed 2-cycle pipeline.

## Interface
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels; N = IMG_W*IMG_H entries processed, N ≤ 65536
- MAG_W, 8, magnitude output width; saturation ceiling 2^MAG_W−1
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a scan when idle
- done  out  1  high from scan completion until next accepted start
- grad_rd  out  1  gradient memory read enable
- grad_addr  out  16  gradient memory read address
- grad_di  in  20  read data {Gx[19:10], Gy[9:0]}, two's complement, valid the cycle after grad_rd
- mag_wr  out  1  magnitude memory write enable
- mag_addr  out  16  magnitude memory write address
- mag_do  out  MAG_W+2  write data {dir[1:0], mag[MAG_W-1:0]}

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE + start → RUN; done cleared; read address counter = 0.
- RUN: grad_rd=1, grad_addr = counter, counter increments each cycle. After issuing address N−1 → DRAIN.
- DRAIN: grad_rd=0; remaining 2 pipeline entries retire; → FIN when the last write (mag_addr N−1) is issued.
- FIN: done=1, → IDLE next cycle. done stays high in IDLE until the next start.
- start while in RUN/DRAIN/FIN is ignored.
- Pipe stage 1: register grad_di plus a delayed valid and address.
- Pipe stage 2: compute the result and drive mag_wr/mag_addr/mag_do.
- Arithmetic:
  - ax = |Gx|, ay = |Gy|, 10-bit unsigned (|−512| = 512 representable).
  - sum = ax+ay, 11-bit.
  - mag = sum > 2^MAG_W−1 ? 2^MAG_W−1 : sum.
- Direction, boundaries inclusive and checked in order:
  - 2·ay ≤ ax → 0 (horizontal)
  - else 2·ax ≤ ay → 2 (vertical)
  - else sign(Gx)==sign(Gy) → 1 (45°)
  - else → 3 (135°)
  - Zero counts as non-negative for the sign test.
- Gx=Gy=0 → dir 0, mag 0.

## Timing
- Reset values: done=0, grad_rd=0, grad_addr=0, mag_wr=0, mag_addr=0, mag_do=0, FSM=IDLE.
- start sampled high at edge k → grad_rd=1 with addr 0 from edge k+1.
- Latency: address presented at edge t → mag_wr with the same address at edge t+2.
- Throughput: one entry per cycle, no stalls.
- Scan length: start to done = N+3 cycles.
- mag_wr is high exactly N cycles per scan; addresses 0..N−1 strictly ascending, no gaps or repeats.
- Address counter is 17-bit internally, so N=65536 terminates correctly; 16-bit outputs wrap only after the final entry.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronously); no further writes; restart requires a new start.

## Configuration
- GRAD_MAG_THRESH_EN defined:
  - adds parameter THRESH (default 16).
  - Any entry with sum < THRESH is written as mag=0, dir=0. Latency unchanged.
- Undefined: no thresholding, no THRESH parameter; behaviour exactly as in Operation.

## Structure
- Shared package `ig_pkg`:
  - GRAD_W=10, ADDR_W=16, DIR_H/DIR_D45/DIR_V/DIR_D135 encodings
  - FSM state enum
  - gradient word field offsets, shared with the gradient stage
- One sub-module: `grad_quant`, combinational {Gx,Gy} → {dir, mag}, instantiated in pipe stage 2; unit-testable alone.

## Test plan
- Word 20'h017FD (Gx=+5, Gy=−3) at addr 0 → mag_do=10'h308 (dir 3, mag 8) at mag_addr 0, two cycles after its read address.
- Gx=10, Gy=5 → 10'h00F (tie on 2·ay=ax gives dir 0). Gx=3, Gy=6 → dir 2, mag 9 → 10'h209.
- Gx=−255, Gy=+255 → sum 510 saturates → 10'h3FF. Gx=−512, Gy=0 → 10'h0FF.
- Full 256×256 scan with a ramp pattern:
  - exactly 65536 writes, addresses 0..65535 in order
  - done rises N+3 cycles after start and holds
  - a second start while busy has no effect
- Assert reset at cycle 1000 of a scan → all outputs 0 on the same edge, no writes afterward; a new start performs a clean full scan.
- With GRAD_MAG_THRESH_EN, THRESH=16: Gx=8, Gy=7 (sum 15) → 10'h000; Gx=8, Gy=8 (sum 16) → 10'h110.

Source files
------------

// File: rtl/ig_pkg.sv
// ig_pkg: shared definitions for the image-gradient stage and its
// downstream gradient-magnitude stage.
//   GRAD_W / ADDR_W  : gradient component width and memory address width
//   GX_LSB / GY_LSB  : field offsets inside a packed {Gx,Gy} gradient word
//   DIR_*            : 2-bit quantized edge-direction encodings
//   state_t          : scan controller states
//   abs_grad()       : magnitude of a two's-complement gradient component
package ig_pkg;

  localparam int GRAD_W = 10;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 2 * GRAD_W;

  localparam int GX_LSB = GRAD_W;
  localparam int GY_LSB = 0;

  localparam logic [1:0] DIR_H    = 2'd0;
  localparam logic [1:0] DIR_D45  = 2'd1;
  localparam logic [1:0] DIR_V    = 2'd2;
  localparam logic [1:0] DIR_D135 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // |g| as an unsigned value of the same width; -512 maps to 512, which
  // still fits because the result is interpreted as unsigned.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] r;
    if (g[GRAD_W-1]) begin
      r = (~g) + 10'd1;
    end else begin
      r = g;
    end
    return r;
  endfunction

endpackage

// File: rtl/grad_quant.sv
// grad_quant: combinational {Gx,Gy} -> {dir, mag}.
//   gx, gy : two's-complement gradient components
//   thresh : entries whose L1 sum is below this are forced to zero
//            (tie to 0 to disable)
//   dir    : quantized edge direction (DIR_* encodings)
//   mag    : L1 magnitude saturated at 2^MAG_W-1
module grad_quant
  import ig_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic [GRAD_W-1:0] gx,
  input  logic [GRAD_W-1:0] gy,
  input  logic [GRAD_W:0]   thresh,
  output logic [1:0]        dir,
  output logic [MAG_W-1:0]  mag
);

  localparam logic [GRAD_W:0] MAG_MAX = (GRAD_W+1)'((1 << MAG_W) - 1);

  logic [GRAD_W-1:0] ax;
  logic [GRAD_W-1:0] ay;
  logic [GRAD_W:0]   sum;

  assign ax  = abs_grad(gx);
  assign ay  = abs_grad(gy);
  assign sum = {1'b0, ax} + {1'b0, ay};

  // Saturate, quantize direction (ordered, inclusive tests), then gate by threshold.
  always_comb begin
    dir = DIR_H;
    mag = {MAG_W{1'b0}};
    if (sum < thresh) begin
      dir = DIR_H;
      mag = {MAG_W{1'b0}};
    end else begin
      if (sum > MAG_MAX) begin
        mag = MAG_MAX[MAG_W-1:0];
      end else begin
        mag = sum[MAG_W-1:0];
      end
      // 2*a is formed by a shift into an extra bit so it cannot overflow.
      if ({ay, 1'b0} <= {1'b0, ax}) begin
        dir = DIR_H;
      end else if ({ax, 1'b0} <= {1'b0, ay}) begin
        dir = DIR_V;
      end else if (gx[GRAD_W-1] == gy[GRAD_W-1]) begin
        dir = DIR_D45;
      end else begin
        dir = DIR_D135;
      end
    end
  end

endmodule

// File: rtl/grad_mag.sv
// grad_mag: scans the gradient memory once per start and writes the
// packed {dir, mag} result for every entry to the magnitude memory.
//   clk, reset      : clock (posedge), asynchronous active-low reset
//   start / done    : one-cycle scan request / completion flag
//   grad_rd/addr/di : gradient memory read port (data one cycle after read)
//   mag_wr/addr/do  : magnitude memory write port, two cycles after the read
// Optional build macro GRAD_MAG_THRESH_EN adds parameter THRESH; entries
// with L1 sum below THRESH are written as zero.
module grad_mag
  import ig_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
`ifdef GRAD_MAG_THRESH_EN
  parameter int THRESH = 16,
`endif
  parameter int MAG_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                done,
  output logic                grad_rd,
  output logic [ADDR_W-1:0]   grad_addr,
  input  logic [WORD_W-1:0]   grad_di,
  output logic                mag_wr,
  output logic [ADDR_W-1:0]   mag_addr,
  output logic [MAG_W+1:0]    mag_do
);

  localparam int N = IMG_W * IMG_H;
  // 17-bit counter so that N = 65536 still has a representable last index.
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_t state;
  state_t state_next;

  logic [ADDR_W:0]   cnt;
  logic              scan_start;
  logic              cnt_en;
  logic              rd_next;
  logic              done_next;

  logic              p_rd;
  logic [ADDR_W-1:0] p_addr;
  logic              s1_v;
  logic [ADDR_W-1:0] s1_addr;
  logic [WORD_W-1:0] s1_data;

  logic [1:0]        q_dir;
  logic [MAG_W-1:0]  q_mag;
  logic [GRAD_W:0]   q_thresh;

`ifdef GRAD_MAG_THRESH_EN
  assign q_thresh = (GRAD_W+1)'(THRESH);
`else
  assign q_thresh = {(GRAD_W+1){1'b0}};
`endif

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (cnt == LAST_CNT) state_next = DRAIN;
        else                 state_next = RUN;
      end
      DRAIN: begin
        // Leave when the write of the final entry is being issued.
        if (s1_v && (s1_addr == LAST_ADDR)) state_next = FIN;
        else                                state_next = DRAIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Controller decodes feeding the registered outputs.
  always_comb begin
    scan_start = (state == IDLE) && start;
    cnt_en     = (state == RUN) && (cnt != LAST_CNT);
    rd_next    = (state_next == RUN);
    if (scan_start) begin
      done_next = 1'b0;
    end else if (state == FIN) begin
      done_next = 1'b1;
    end else begin
      done_next = done;
    end
  end

  // Read-address counter and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      grad_rd <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (scan_start) begin
        cnt <= '0;
      end else if (cnt_en) begin
        cnt <= cnt + 17'd1;
      end else begin
        cnt <= cnt;
      end
      grad_rd <= rd_next;
      done    <= done_next;
    end
  end

  assign grad_addr = cnt[ADDR_W-1:0];

  // Read tracking and pipe stage 1: align valid/address with returned data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_rd    <= 1'b0;
      p_addr  <= '0;
      s1_v    <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      p_rd    <= grad_rd;
      p_addr  <= grad_addr;
      s1_v    <= p_rd;
      s1_addr <= p_addr;
      s1_data <= grad_di;
    end
  end

  grad_quant #(.MAG_W(MAG_W)) u_quant (
    .gx     (s1_data[GX_LSB +: GRAD_W]),
    .gy     (s1_data[GY_LSB +: GRAD_W]),
    .thresh (q_thresh),
    .dir    (q_dir),
    .mag    (q_mag)
  );

  // Pipe stage 2: registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_wr   <= 1'b0;
      mag_addr <= '0;
      mag_do   <= '0;
    end else begin
      mag_wr <= s1_v;
      if (s1_v) begin
        mag_addr <= s1_addr;
        mag_do   <= {q_dir, q_mag};
      end else begin
        mag_addr <= mag_addr;
        mag_do   <= mag_do;
      end
    end
  end

endmodule

// File: tb/tb_grad_mag.sv
module tb_grad_mag;

  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int MAG_W = 8;
  localparam int N     = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        grad_rd;
  logic [15:0] grad_addr;
  logic [19:0] grad_di;
  logic        mag_wr;
  logic [15:0] mag_addr;
  logic [9:0]  mag_do;

  logic [19:0] mem     [N];
  logic [9:0]  exp_tab [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read gradient memory model.
  always @(posedge clk) begin
    if (grad_rd) grad_di <= mem[grad_addr];
  end

  grad_mag #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
`ifdef GRAD_MAG_THRESH_EN
    .THRESH(16),
`endif
    .MAG_W(MAG_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .grad_rd(grad_rd), .grad_addr(grad_addr), .grad_di(grad_di),
    .mag_wr(mag_wr), .mag_addr(mag_addr), .mag_do(mag_do)
  );

  // Integer reference for the ramp scans.
  function automatic logic [9:0] model_word(input logic [19:0] w);
    int gx, gy, ax, ay, sum, mag, dir;
    gx  = int'($signed(w[19:10]));
    gy  = int'($signed(w[9:0]));
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    sum = ax + ay;
    mag = (sum > 255) ? 255 : sum;
    if (2 * ay <= ax)                 dir = 0;
    else if (2 * ax <= ay)            dir = 2;
    else if ((gx >= 0) == (gy >= 0))  dir = 1;
    else                              dir = 3;
`ifdef GRAD_MAG_THRESH_EN
    if (sum < 16) begin
      dir = 0;
      mag = 0;
    end
`endif
    return 10'(dir * 256 + mag);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (grad_rd !== 1'b0)   begin errors++; $display("FAIL reset_grad_rd: got %0b want 0", grad_rd); end
    checks++; if (grad_addr !== 16'h0) begin errors++; $display("FAIL reset_grad_addr: got %h want 0", grad_addr); end
    checks++; if (mag_wr !== 1'b0)    begin errors++; $display("FAIL reset_mag_wr: got %0b want 0", mag_wr); end
    checks++; if (mag_addr !== 16'h0) begin errors++; $display("FAIL reset_mag_addr: got %h want 0", mag_addr); end
    checks++; if (mag_do !== 10'h0)   begin errors++; $display("FAIL reset_mag_do: got %h want 0", mag_do); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Directed words at the head of memory, zeros elsewhere.
  task automatic test_vectors();
    int hits;
    for (int i = 0; i < N; i++) begin
      mem[i]     = 20'h0;
      exp_tab[i] = 10'h0;
    end
    mem[0] = 20'h017FD;  // Gx=+5,   Gy=-3
    mem[1] = 20'h02805;  // Gx=10,   Gy=5   (tie 2*ay == ax)
    mem[2] = 20'h00C06;  // Gx=3,    Gy=6
    mem[3] = 20'hC04FF;  // Gx=-255, Gy=+255 (saturates)
    mem[4] = 20'h80000;  // Gx=-512, Gy=0
    mem[5] = 20'h00000;  // zero
    mem[6] = 20'hFF3FC;  // Gx=-4,   Gy=-4
    mem[7] = 20'h02007;  // Gx=8,    Gy=7   (sum 15)
    mem[8] = 20'h02008;  // Gx=8,    Gy=8   (sum 16)
`ifdef GRAD_MAG_THRESH_EN
    exp_tab[0] = 10'h000; exp_tab[1] = 10'h000; exp_tab[2] = 10'h000;
    exp_tab[3] = 10'h3FF; exp_tab[4] = 10'h0FF; exp_tab[5] = 10'h000;
    exp_tab[6] = 10'h000; exp_tab[7] = 10'h000; exp_tab[8] = 10'h110;
`else
    exp_tab[0] = 10'h308; exp_tab[1] = 10'h00F; exp_tab[2] = 10'h209;
    exp_tab[3] = 10'h3FF; exp_tab[4] = 10'h0FF; exp_tab[5] = 10'h000;
    exp_tab[6] = 10'h108; exp_tab[7] = 10'h10F; exp_tab[8] = 10'h110;
`endif
    hits = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= N + 3; j++) begin
      @(posedge clk);
      #1;
      if (mag_wr && (mag_addr < 16'd9)) begin
        hits++;
        checks++;
        if (int'(mag_addr) != j - 3) begin
          errors++; $display("FAIL vec_latency: addr %0d written at cycle %0d want cycle %0d", mag_addr, j, int'(mag_addr) + 3);
        end
        checks++;
        if (mag_do !== exp_tab[mag_addr]) begin
          errors++; $display("FAIL vec_data[%0d]: got %h want %h", mag_addr, mag_do, exp_tab[mag_addr]);
        end
      end
    end
    checks++; if (hits != 9)   begin errors++; $display("FAIL vec_hits: got %0d want 9", hits); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL vec_done: got %0b want 1", done); end
  endtask

  task automatic load_ramp();
    logic [9:0] a;
    logic [9:0] b;
    for (int i = 0; i < N; i++) begin
      a          = 10'(i * 5 + 100);
      b          = 10'(i * 13);
      mem[i]     = {a, b};
      exp_tab[i] = model_word({a, b});
    end
  endtask

  // Full scan: cycle-exact write stream, done timing, ignored restarts.
  task automatic test_full_scan();
    int wr_cnt;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (grad_rd !== 1'b1)    begin errors++; $display("FAIL scan_first_rd: got %0b want 1", grad_rd); end
    checks++; if (grad_addr !== 16'h0) begin errors++; $display("FAIL scan_first_addr: got %h want 0", grad_addr); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL scan_done_clear: got %0b want 0", done); end
    for (int j = 1; j <= N + 5; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (grad_rd !== (j < N)) begin
        errors++; $display("FAIL scan_rd cycle %0d: got %0b want %0b", j, grad_rd, (j < N));
      end
      if (j < N) begin
        checks++;
        if (int'(grad_addr) != j) begin errors++; $display("FAIL scan_raddr cycle %0d: got %0d want %0d", j, grad_addr, j); end
      end
      checks++;
      if (mag_wr !== ((j >= 3) && (j <= N + 2))) begin
        errors++; $display("FAIL scan_wr cycle %0d: got %0b want %0b", j, mag_wr, ((j >= 3) && (j <= N + 2)));
      end
      if (mag_wr) begin
        wr_cnt++;
        checks++;
        if (int'(mag_addr) != j - 3) begin errors++; $display("FAIL scan_waddr cycle %0d: got %0d want %0d", j, mag_addr, j - 3); end
        if ((j >= 3) && (j <= N + 2)) begin
          checks++;
          if (mag_do !== exp_tab[j-3]) begin errors++; $display("FAIL scan_data[%0d]: got %h want %h", j - 3, mag_do, exp_tab[j-3]); end
        end
      end
      checks++;
      if (done !== (j >= N + 3)) begin
        errors++; $display("FAIL scan_done cycle %0d: got %0b want %0b", j, done, (j >= N + 3));
      end
      // Start pulses landing in RUN, DRAIN and FIN must all be ignored.
      start = (j == 10) || (j == N + 1) || (j == N + 2);
    end
    start = 1'b0;
    checks++; if (wr_cnt != N) begin errors++; $display("FAIL scan_wr_count: got %0d want %0d", wr_cnt, N); end
  endtask

  // Reset 1000 cycles into a scan, then confirm a clean restart.
  task automatic test_reset_mid_scan();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (1000) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (mag_wr !== 1'b0 || mag_addr !== 16'h0 || mag_do !== 10'h0) begin
      errors++; $display("FAIL midrst_write_port: got wr=%0b addr=%h do=%h want all 0", mag_wr, mag_addr, mag_do);
    end
    checks++; if (grad_rd !== 1'b0 || grad_addr !== 16'h0) begin
      errors++; $display("FAIL midrst_read_port: got rd=%0b addr=%h want all 0", grad_rd, grad_addr);
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b want 0", done); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mag_wr !== 1'b0 || grad_rd !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet cycle %0d: got wr=%0b rd=%0b want 0 0", j, mag_wr, grad_rd);
      end
    end
    test_full_scan();
  endtask

  initial begin
    test_reset();
    test_vectors();
    load_ramp();
    test_full_scan();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
